// File: rtl/cpu_types_pkg.sv
// Shared datapath types for the EX-stage multiply/divide unit.
package cpu_types_pkg;

    localparam int unsigned MD_WIDTH = 32;

    typedef enum logic [1:0] {
        MD_MULTU = 2'd0,
        MD_MULT  = 2'd1,
        MD_DIVU  = 2'd2,
        MD_DIV   = 2'd3
    } mdop_t;

    typedef enum logic [1:0] {
        MDS_IDLE = 2'd0,
        MDS_CALC = 2'd1,
        MDS_FIX  = 2'd2,
        MDS_DONE = 2'd3
    } md_state_t;

endpackage

// File: rtl/alu_muldiv_if.sv
// Bundle of multiply/divide unit signals, mirroring the ALU interface.
interface alu_muldiv_if
    import cpu_types_pkg::*;
#(
    parameter int unsigned WIDTH = MD_WIDTH
) (
    input logic CLK
);
    logic             nRST;
    logic             start;
    mdop_t            op;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             divzero;

    modport md (
        input  CLK, nRST, start, op, opa, opb, flush,
        output busy, done, hi, lo, divzero
    );

    modport tb (
        input  CLK, busy, done, hi, lo, divzero,
        output nRST, start, op, opa, opb, flush
    );
endinterface

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply or restoring divide.
// Multiply: acc = {partial product, remaining multiplier bits}, b = multiplicand.
// Divide:   acc[WIDTH-1:0] = dividend shifting out / quotient shifting in,
//           rem = partial remainder, b = divisor.
module muldiv_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic               is_div,
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   rem,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] acc_n,
    output logic [WIDTH-1:0]   rem_n
);
    logic [WIDTH:0] sum;
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // Compute both iteration flavours and select by operation
    always_comb begin
        sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, b} : (WIDTH+1)'(0));
        shifted = {rem, acc[WIDTH-1]};
        diff    = shifted - {1'b0, b};
        acc_n   = {sum, acc[WIDTH-1:1]};
        rem_n   = rem;
        if (is_div) begin
            if (!diff[WIDTH]) begin
                rem_n = diff[WIDTH-1:0];
                acc_n = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-2:0], 1'b1};
            end else begin
                rem_n = shifted[WIDTH-1:0];
                acc_n = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/alu_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit: magnitude iterations, sign fix-up at the end.
module alu_muldiv_unit
    import cpu_types_pkg::*;
#(
    parameter int unsigned WIDTH = MD_WIDTH
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             start,
    input  mdop_t            op,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             divzero
);
    localparam int unsigned CNTW = $clog2(WIDTH + 1);

    md_state_t          state, state_n;
    logic               is_div_q, neg_q, neg_r;
    logic [WIDTH-1:0]   b_q;
    logic [2*WIDTH-1:0] acc, acc_n;
    logic [WIDTH-1:0]   rem, rem_n;
    logic [CNTW-1:0]    cnt;

    logic               accept, op_div, op_signed;
    logic [WIDTH-1:0]   a_in, b_in;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo, rmd, fix_hi, fix_lo;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? WIDTH'(-x) : x;
    endfunction

    // Request decode and operand magnitudes for the iteration datapath
    always_comb begin
        op_div    = (op == MD_DIVU) || (op == MD_DIV);
        op_signed = (op == MD_MULT) || (op == MD_DIV);
        accept    = (state == MDS_IDLE) && start && !flush;
        a_in      = op_signed ? mag(opa) : opa;
        b_in      = op_signed ? mag(opb) : opb;
    end

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div (is_div_q),
        .acc    (acc),
        .rem    (rem),
        .b      (b_q),
        .acc_n  (acc_n),
        .rem_n  (rem_n)
    );

    // Sign fix-up of the magnitude results
    always_comb begin
        prod   = neg_q ? (2*WIDTH)'(-acc) : acc;
        quo    = neg_q ? WIDTH'(-acc[WIDTH-1:0]) : acc[WIDTH-1:0];
        rmd    = neg_r ? WIDTH'(-rem) : rem;
        fix_hi = is_div_q ? rmd : prod[2*WIDTH-1:WIDTH];
        fix_lo = is_div_q ? quo : prod[WIDTH-1:0];
    end

    // State register
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state <= MDS_IDLE;
        else       state <= state_n;
    end

    // Next-state logic; flush always returns to IDLE
    always_comb begin
        state_n = state;
        case (state)
            MDS_IDLE: if (accept) state_n = (op_div && opb == '0) ? MDS_DONE : MDS_CALC;
            MDS_CALC: if (cnt == CNTW'(WIDTH - 1)) state_n = MDS_FIX;
            MDS_FIX:  state_n = MDS_DONE;
            MDS_DONE: state_n = MDS_IDLE;
            default:  state_n = MDS_IDLE;
        endcase
        if (flush) state_n = MDS_IDLE;
    end

    // Operand capture, iteration registers and registered outputs
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            divzero  <= 1'b0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            b_q      <= '0;
            acc      <= '0;
            rem      <= '0;
            cnt      <= '0;
        end else begin
            busy <= (state_n != MDS_IDLE);
            done <= (state_n == MDS_DONE);
            case (state)
                MDS_IDLE: begin
                    if (accept) begin
                        is_div_q <= op_div;
                        neg_q    <= op_signed && (opa[WIDTH-1] ^ opb[WIDTH-1]);
                        neg_r    <= op_signed && opa[WIDTH-1];
                        divzero  <= 1'b0;
                        cnt      <= '0;
                        rem      <= '0;
                        b_q      <= op_div ? b_in : a_in;
                        acc      <= {WIDTH'(0), op_div ? a_in : b_in};
                        if (op_div && opb == '0) begin
                            divzero <= 1'b1;
                            hi      <= opa;
                            lo      <= '1;
                        end
                    end
                end
                MDS_CALC: begin
                    acc <= acc_n;
                    rem <= rem_n;
                    cnt <= cnt + CNTW'(1);
                end
                MDS_FIX: begin
                    if (!flush) begin
                        hi <= fix_hi;
                        lo <= fix_lo;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_muldiv_unit.sv
// Self-checking bench for alu_muldiv_unit against a plain-arithmetic reference.
module tb_alu_muldiv_unit;
    import cpu_types_pkg::*;

    localparam int W        = 32;
    localparam int NORM_LAT = W + 2;

    logic CLK = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    always #5 CLK = ~CLK;

    alu_muldiv_if #(.WIDTH(W)) mif (.CLK(CLK));

    alu_muldiv_unit #(.WIDTH(W)) dut (
        .CLK     (CLK),
        .nRST    (mif.nRST),
        .start   (mif.start),
        .op      (mif.op),
        .opa     (mif.opa),
        .opb     (mif.opb),
        .flush   (mif.flush),
        .busy    (mif.busy),
        .done    (mif.done),
        .hi      (mif.hi),
        .lo      (mif.lo),
        .divzero (mif.divzero)
    );

    // Reference: 64-bit arithmetic, SV signed division truncates toward zero
    function automatic void model(input mdop_t o, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] h, output logic [31:0] l, output logic dz);
        longint          sa, sb, p;
        longint unsigned ua, ub, up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        dz = 1'b0;
        h  = '0;
        l  = '0;
        case (o)
            MD_MULTU: begin up = ua * ub; h = up[63:32]; l = up[31:0]; end
            MD_MULT:  begin p = sa * sb;  h = p[63:32];  l = p[31:0];  end
            default: begin
                if (b == 32'd0) begin
                    dz = 1'b1; h = a; l = 32'hFFFF_FFFF;
                end else if (o == MD_DIVU) begin
                    up = ua / ub; l = up[31:0];
                    up = ua % ub; h = up[31:0];
                end else begin
                    p = sa / sb; l = p[31:0];
                    p = sa % sb; h = p[31:0];
                end
            end
        endcase
    endfunction

    // Issue one op and wait for done; returns with the unit back in IDLE
    task automatic run_op(input mdop_t o, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] rh, output logic [31:0] rl, output logic rdz,
                          output int lat, output int busy_n);
        @(negedge CLK);
        mif.op = o; mif.opa = a; mif.opb = b; mif.start = 1'b1;
        @(posedge CLK); #1;
        mif.start = 1'b0;
        lat = 0; busy_n = 0;
        for (int c = 1; c <= 200; c++) begin
            if (mif.busy) busy_n++;
            if (mif.done) begin lat = c; break; end
            @(posedge CLK); #1;
        end
        rh = mif.hi; rl = mif.lo; rdz = mif.divzero;
        @(posedge CLK); #1;
    endtask

    task automatic test_reset();
        @(negedge CLK);
        checks++; if (mif.busy !== 1'b0)     begin failures++; $display("FAIL reset_busy got=%b exp=0", mif.busy); end
        checks++; if (mif.done !== 1'b0)     begin failures++; $display("FAIL reset_done got=%b exp=0", mif.done); end
        checks++; if (mif.hi !== 32'd0)      begin failures++; $display("FAIL reset_hi got=%h exp=0", mif.hi); end
        checks++; if (mif.lo !== 32'd0)      begin failures++; $display("FAIL reset_lo got=%h exp=0", mif.lo); end
        checks++; if (mif.divzero !== 1'b0)  begin failures++; $display("FAIL reset_divzero got=%b exp=0", mif.divzero); end
    endtask

    task automatic test_directed();
        mdop_t       dop [6];
        logic [31:0] da [6], db [6], eh [6], el [6];
        logic        edz [6];
        int          elat [6];
        logic [31:0] h, l;
        logic        dz;
        int          lat, bn;
        dop  = '{MD_MULT, MD_MULTU, MD_DIV, MD_DIV, MD_DIVU, MD_DIVU};
        da   = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'h8000_0000, 32'h1234_5678, 32'd100};
        db   = '{32'h0000_0005, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'h0000_0000, 32'd7};
        eh   = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000, 32'h1234_5678, 32'h0000_0002};
        el   = '{32'hFFFF_FFF1, 32'h0000_0001, 32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_000E};
        edz  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        elat = '{NORM_LAT, NORM_LAT, NORM_LAT, NORM_LAT, 1, NORM_LAT};
        for (int i = 0; i < 6; i++) begin
            run_op(dop[i], da[i], db[i], h, l, dz, lat, bn);
            checks++; if (h !== eh[i])    begin failures++; $display("FAIL dir%0d_hi got=%h exp=%h", i, h, eh[i]); end
            checks++; if (l !== el[i])    begin failures++; $display("FAIL dir%0d_lo got=%h exp=%h", i, l, el[i]); end
            checks++; if (dz !== edz[i])  begin failures++; $display("FAIL dir%0d_divzero got=%b exp=%b", i, dz, edz[i]); end
            checks++; if (lat != elat[i]) begin failures++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, elat[i]); end
            checks++; if (bn != elat[i])  begin failures++; $display("FAIL dir%0d_busy_cycles got=%0d exp=%0d", i, bn, elat[i]); end
        end
    endtask

    task automatic test_random();
        mdop_t       o;
        logic [31:0] a, b, h, l, mh, ml;
        logic        dz, mdz;
        int          lat, bn, sel;
        for (int i = 0; i < 30; i++) begin
            o   = mdop_t'($urandom_range(0, 3));
            a   = $urandom;
            sel = $urandom_range(0, 7);
            case (sel)
                0:       b = 32'd0;
                1:       b = 32'hFFFF_FFFF;
                2:       b = $urandom_range(1, 20);
                3:       begin a = 32'h8000_0000; b = $urandom; end
                default: b = $urandom;
            endcase
            model(o, a, b, mh, ml, mdz);
            run_op(o, a, b, h, l, dz, lat, bn);
            checks++; if (h !== mh)   begin failures++; $display("FAIL rnd%0d_hi op=%0d a=%h b=%h got=%h exp=%h", i, o, a, b, h, mh); end
            checks++; if (l !== ml)   begin failures++; $display("FAIL rnd%0d_lo op=%0d a=%h b=%h got=%h exp=%h", i, o, a, b, l, ml); end
            checks++; if (dz !== mdz) begin failures++; $display("FAIL rnd%0d_divzero got=%b exp=%b", i, dz, mdz); end
            checks++; if (lat != (mdz ? 1 : NORM_LAT)) begin failures++; $display("FAIL rnd%0d_latency got=%0d exp=%0d", i, lat, mdz ? 1 : NORM_LAT); end
        end
    endtask

    task automatic test_flush();
        logic [31:0] h, l;
        logic        dz;
        int          lat, bn, saw_done;
        run_op(MD_MULTU, 32'd7, 32'd9, h, l, dz, lat, bn);
        @(negedge CLK);
        mif.op = MD_MULTU; mif.opa = 32'd3; mif.opb = 32'd4; mif.start = 1'b1;
        @(posedge CLK); #1;
        mif.start = 1'b0;
        for (int c = 1; c < 10; c++) begin @(posedge CLK); #1; end
        @(negedge CLK); mif.flush = 1'b1;
        @(posedge CLK); #1;
        mif.flush = 1'b0;
        checks++; if (mif.busy !== 1'b0) begin failures++; $display("FAIL flush_idle busy=%b exp=0", mif.busy); end
        saw_done = 0;
        for (int c = 0; c < 40; c++) begin
            if (mif.done) saw_done++;
            @(posedge CLK); #1;
        end
        checks++; if (saw_done != 0)        begin failures++; $display("FAIL flush_no_done pulses=%0d exp=0", saw_done); end
        checks++; if (mif.hi !== 32'd0)     begin failures++; $display("FAIL flush_hi_kept got=%h exp=0", mif.hi); end
        checks++; if (mif.lo !== 32'd63)    begin failures++; $display("FAIL flush_lo_kept got=%h exp=3f", mif.lo); end
        checks++; if (mif.busy !== 1'b0)    begin failures++; $display("FAIL flush_stays_idle busy=%b", mif.busy); end
    endtask

    task automatic test_start_while_busy();
        int lat;
        @(negedge CLK);
        mif.op = MD_MULT; mif.opa = 32'hFFFF_FFFD; mif.opb = 32'd5; mif.start = 1'b1;
        @(posedge CLK); #1;
        mif.start = 1'b0;
        lat = 0;
        for (int c = 1; c <= 200; c++) begin
            if (c == 5) begin
                mif.op = MD_DIVU; mif.opa = 32'd100; mif.opb = 32'd0; mif.start = 1'b1;
            end else begin
                mif.start = 1'b0;
            end
            if (mif.done) begin lat = c; break; end
            @(posedge CLK); #1;
        end
        mif.start = 1'b0;
        checks++; if (lat != NORM_LAT)           begin failures++; $display("FAIL swb_latency got=%0d exp=%0d", lat, NORM_LAT); end
        checks++; if (mif.hi !== 32'hFFFF_FFFF)  begin failures++; $display("FAIL swb_hi got=%h exp=ffffffff", mif.hi); end
        checks++; if (mif.lo !== 32'hFFFF_FFF1)  begin failures++; $display("FAIL swb_lo got=%h exp=fffffff1", mif.lo); end
        checks++; if (mif.divzero !== 1'b0)      begin failures++; $display("FAIL swb_divzero got=%b exp=0", mif.divzero); end
        @(posedge CLK); #1;
    endtask

    task automatic test_async_reset();
        logic [31:0] h, l;
        logic        dz;
        int          lat, bn;
        run_op(MD_DIVU, 32'd5, 32'd0, h, l, dz, lat, bn);
        @(negedge CLK);
        mif.op = MD_MULT; mif.opa = 32'h1234; mif.opb = 32'h55; mif.start = 1'b1;
        @(posedge CLK); #1;
        mif.start = 1'b0;
        for (int c = 0; c < 10; c++) begin @(posedge CLK); #1; end
        #2 mif.nRST = 1'b0;
        #1;
        checks++; if (mif.busy !== 1'b0)    begin failures++; $display("FAIL arst_busy got=%b exp=0", mif.busy); end
        checks++; if (mif.done !== 1'b0)    begin failures++; $display("FAIL arst_done got=%b exp=0", mif.done); end
        checks++; if (mif.hi !== 32'd0)     begin failures++; $display("FAIL arst_hi got=%h exp=0", mif.hi); end
        checks++; if (mif.lo !== 32'd0)     begin failures++; $display("FAIL arst_lo got=%h exp=0", mif.lo); end
        checks++; if (mif.divzero !== 1'b0) begin failures++; $display("FAIL arst_divzero got=%b exp=0", mif.divzero); end
        @(negedge CLK); mif.nRST = 1'b1;
        run_op(MD_MULT, 32'd2, 32'd3, h, l, dz, lat, bn);
        checks++; if (l !== 32'd6)      begin failures++; $display("FAIL arst_after_lo got=%h exp=6", l); end
        checks++; if (h !== 32'd0)      begin failures++; $display("FAIL arst_after_hi got=%h exp=0", h); end
        checks++; if (lat != NORM_LAT)  begin failures++; $display("FAIL arst_after_latency got=%0d exp=%0d", lat, NORM_LAT); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        mif.nRST  = 1'b0;
        mif.start = 1'b0;
        mif.flush = 1'b0;
        mif.op    = MD_MULTU;
        mif.opa   = '0;
        mif.opb   = '0;
        #23 mif.nRST = 1'b1;
        test_reset();
        test_directed();
        test_random();
        test_flush();
        test_start_while_busy();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
